// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B transmit link-layer sequencer for one lane: CGS, 4-multiframe ILAS, then data
// pass-through, with SYNC~ error-report counting and resynchronisation handling.
module jesd204b_tx_link_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int MF_CYCLES  = 16,
    parameter bit SCRAMBLE   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sync_n,
    input  logic [DATA_WIDTH-1:0]        tx_data,
    output logic                         tx_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [3:0]                   out_k,
    output logic                         scr_en,
    output logic                         scr_rst,
    output logic [$clog2(MF_CYCLES)-1:0] lmfc_cnt,
    output logic [1:0]                   link_state,
    output logic [7:0]                   err_cnt
);

    localparam int CW = $clog2(MF_CYCLES);
    localparam logic [CW-1:0] LMFC_LAST = CW'(MF_CYCLES - 1);
    localparam logic [7:0]    OCT_LAST  = 8'(4 * MF_CYCLES - 1);

    typedef enum logic [1:0] {
        CGS  = 2'd0,
        ILAS = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  sync_m, sync_s;
    logic [1:0]            mf, mf_nxt;
    logic [1:0]            run_cnt, run_nxt;
    logic [7:0]            err_nxt;
    logic                  lmfc_wrap;
    logic [DATA_WIDTH-1:0] word;
    logic [3:0]            word_k;
    logic [7:0]            oct;

    assign lmfc_wrap  = (lmfc_cnt == LMFC_LAST);
    assign link_state = state;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_m   <= 1'b0;
            sync_s   <= 1'b0;
            lmfc_cnt <= '0;
            state    <= CGS;
            mf       <= '0;
            run_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            sync_m   <= sync_n;
            sync_s   <= sync_m;
            lmfc_cnt <= lmfc_wrap ? '0 : lmfc_cnt + CW'(1);
            state    <= state_nxt;
            mf       <= mf_nxt;
            run_cnt  <= run_nxt;
            err_cnt  <= err_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        mf_nxt    = mf;
        run_nxt   = run_cnt;
        err_nxt   = err_cnt;
        if (state == ILAS || state == DATA) begin
            if (state == ILAS && lmfc_wrap) begin
                mf_nxt = mf + 2'd1;
                if (mf == 2'd3)
                    state_nxt = DATA;
            end
            // A fourth consecutive low overrides ILAS completion and restarts from CGS.
            if (!sync_s) begin
                if (run_cnt == 2'd3) begin
                    state_nxt = CGS;
                    run_nxt   = '0;
                    mf_nxt    = '0;
                end else begin
                    run_nxt = run_cnt + 2'd1;
                end
            end else begin
                run_nxt = '0;
                if (run_cnt != 2'd0 && err_cnt != 8'hFF)
                    err_nxt = err_cnt + 8'd1;
            end
        end else begin
            run_nxt   = '0;
            mf_nxt    = '0;
            state_nxt = (sync_s && lmfc_wrap) ? ILAS : CGS;
        end
    end

    always_comb begin
        word   = '0;
        word_k = '0;
        oct    = '0;
        case (state)
            CGS: begin
                word   = {4{8'hBC}};
                word_k = 4'hF;
            end
            ILAS: begin
                for (int p = 0; p < 4; p++) begin
                    oct = 8'({lmfc_cnt, 2'(p)});
                    if (oct == 8'd0) begin
                        word[DATA_WIDTH-1-8*p -: 8] = 8'h1C;
                        word_k[3-p]                 = 1'b1;
                    end else if (oct == OCT_LAST) begin
                        word[DATA_WIDTH-1-8*p -: 8] = 8'h7C;
                        word_k[3-p]                 = 1'b1;
                    end else if (mf == 2'd1 && oct == 8'd1) begin
                        word[DATA_WIDTH-1-8*p -: 8] = 8'h9C;
                        word_k[3-p]                 = 1'b1;
                    end else begin
                        word[DATA_WIDTH-1-8*p -: 8] = oct;
                    end
                end
            end
            DATA: word = tx_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
            out_k    <= '0;
            tx_ready <= 1'b0;
            scr_en   <= 1'b0;
            scr_rst  <= 1'b1;
        end else begin
            out_data <= word;
            out_k    <= word_k;
            tx_ready <= (state == DATA);
            scr_en   <= (state == DATA) && SCRAMBLE;
            scr_rst  <= (state != DATA);
        end
    end

endmodule
